binary_mul_14_1_uni: RTL and testbench

- Unsigned 14x14 binary multiplier with one registered output stage; product P = A*B is available one clock after the inputs are sampled.
- Purely combinational partial-product array feeding a single output register. The datapath is the "1-stage, unsigned" member of the team's binary-multiplier family.
- Used as a leaf arithmetic block; no handshake beyond a clock-enable.

---
 rtl/bmul_pkg.sv | 10 +
 rtl/bmul_full_adder.sv | 16 +
 rtl/binary_mul_14_1_uni.sv | 110 +++++++++++
 tb/tb_binary_mul_14_1_uni.sv | 136 +++++++++++++
 4 files changed

// File: rtl/bmul_pkg.sv
// Shared constants and operand/product types for the binary-multiplier family.
package bmul_pkg;

  localparam int unsigned BMUL_W  = 14;
  localparam int unsigned BMUL_PW = 2 * BMUL_W;

  typedef logic [BMUL_W-1:0]  bmul_op_t;
  typedef logic [BMUL_PW-1:0] bmul_prod_t;

endpackage

// File: rtl/bmul_full_adder.sv
// One-bit full adder cell; used as a half adder by tying cin to 0.
module bmul_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic ab_x;

  assign ab_x = a ^ b;
  assign s    = ab_x ^ cin;
  assign cout = (a & b) | (cin & ab_x);

endmodule

// File: rtl/binary_mul_14_1_uni.sv
// Unsigned WIDTHxWIDTH carry-save array multiplier with a single registered output stage.
// Optional macro BMUL_SELFCHECK_EN compiles in a simulation-only product checker.
module binary_mul_14_1_uni
  import bmul_pkg::*;
#(
  parameter int unsigned WIDTH = BMUL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0] prod;
  logic [PW-1:0] p_d, p_q;

  // Row j holds sums of weight 2^(j+i) and carries of weight 2^(j+i+1).
  for (genvar j = 0; j < WIDTH; j++) begin : g_row
    logic [WIDTH-1:0] pp;
    logic [WIDTH-1:0] s_row;
    logic [WIDTH-1:0] c_row;

    assign pp = A & {WIDTH{B[j]}};

    if (j == 0) begin : g_first
      assign s_row = pp;
      assign c_row = '0;
    end else begin : g_csa
      logic [WIDTH-1:0] s_in;
      assign s_in = {1'b0, g_row[j-1].s_row[WIDTH-1:1]};
      for (genvar i = 0; i < WIDTH; i++) begin : g_col
        bmul_full_adder u_fa (
          .a   (pp[i]),
          .b   (s_in[i]),
          .cin (g_row[j-1].c_row[i]),
          .s   (s_row[i]),
          .cout(c_row[i])
        );
      end
    end

    assign prod[j] = s_row[0];
  end

  // Final ripple merges the last row's sums and carries into the upper half.
  for (genvar k = 0; k < WIDTH - 1; k++) begin : g_rca
    logic ci;
    logic co;

    if (k == 0) begin : g_lsb
      assign ci = 1'b0;
    end else begin : g_up
      assign ci = g_rca[k-1].co;
    end

    bmul_full_adder u_fa (
      .a   (g_row[WIDTH-1].s_row[k+1]),
      .b   (g_row[WIDTH-1].c_row[k]),
      .cin (ci),
      .s   (prod[WIDTH+k]),
      .cout(co)
    );
  end

  // The product fits in PW bits, so the top position can never carry out.
  assign prod[PW-1] = g_row[WIDTH-1].c_row[WIDTH-1] ^ g_rca[WIDTH-2].co;

  always_comb begin
    p_d = p_q;
    if (en) begin
      p_d = prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign P = p_q;

`ifdef BMUL_SELFCHECK_EN
  logic [PW-1:0] chk_exp_q;
  logic          chk_vld_q;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_vld_q <= 1'b0;
      chk_exp_q <= '0;
    end else begin
      if (chk_vld_q && (p_q !== chk_exp_q)) begin
        $error("bmul selfcheck: P=%0d expected %0d", p_q, chk_exp_q);
      end
      chk_vld_q <= en;
      if (en) begin
        chk_exp_q <= {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_binary_mul_14_1_uni.sv
// Scoreboard bench for binary_mul_14_1_uni: expected products queued on accepted edges,
// a monitor pops and compares every cycle.
module tb_binary_mul_14_1_uni;
  import bmul_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic [13:0]      A = '0;
  logic [13:0]      B = '0;
  logic [27:0]      P;

  int checks = 0;
  int failures = 0;

  longint unsigned exp_q[$];
  longint unsigned last_exp = 0;

  always #5 clk = ~clk;

  binary_mul_14_1_uni dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .A    (A),
    .B    (B),
    .P    (P)
  );

  function automatic longint unsigned ref_mul(longint unsigned a, longint unsigned b);
    return a * b;
  endfunction

  task automatic check(string name, longint unsigned got, longint unsigned want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, want, $time);
    end
  endtask

  // Reference: an accepted edge schedules A*B as the next visible product.
  always @(posedge clk) begin
    if (rst_n && en) exp_q.push_back(ref_mul(64'(A), 64'(B)));
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      exp_q.delete();
      last_exp = 0;
    end else if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
    end
    check("pipe", 64'(P), last_exp);
  end

  task automatic drive(input logic [13:0] a, input logic [13:0] b, input logic e);
    @(negedge clk);
    A  = a;
    B  = b;
    en = e;
  endtask

  task automatic dir(string name, input logic [13:0] a, input logic [13:0] b,
                     input longint unsigned want);
    drive(a, b, 1'b1);
    @(posedge clk);
    #2;
    check(name, 64'(P), want);
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    A     = 14'd5;
    B     = 14'd7;
    #1;
    check("rst_init", 64'(P), 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #2;
      check("rst_hold", 64'(P), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    dir("basic_3x4", 14'd3, 14'd4, 12);
    dir("zero_a", 14'd0, 14'd16383, 0);
    dir("max_max", 14'd16383, 14'd16383, 64'h0FFF8001);
    dir("one_max", 14'd1, 14'd16383, 16383);
    dir("pow2", 14'd8192, 14'd2, 16384);

    dir("hold_load", 14'd100, 14'd200, 20000);
    for (int c = 0; c < 3; c++) begin
      drive(14'd9, 14'd9, 1'b0);
      @(posedge clk);
      #2;
      check("hold_en0", 64'(P), 20000);
    end
    dir("hold_release", 14'd9, 14'd9, 81);

    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j += 17) begin
        drive(14'(i), 14'(j), 1'b1);
      end
    end

    for (int n = 0; n < 4000; n++) begin
      drive(14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)),
            ($urandom_range(0, 7) != 0));
    end

    dir("pre_async", 14'd3, 14'd4, 12);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst", 64'(P), 0);
    @(posedge clk);
    #2;
    check("rst_edge", 64'(P), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dir("post_rst", 14'd1000, 14'd1000, 1000000);

    drive(14'd0, 14'd0, 1'b0);
    drive(14'd0, 14'd0, 1'b0);
    @(posedge clk);
    #2;
    check("drain", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
